// File: rtl/pb_io_pkg.sv
// pb_io_pkg: shared types and helpers for the PicoBlaze I/O hub.
//   irq_state_e      - interrupt controller FSM states
//   DefaultMaskAddr  - default address of the interrupt mask register
//   DefaultStatAddr  - default address of the interrupt pending register
//   addr_in_range()  - true when addr lies in [base, base+num-1]
package pb_io_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StWaitClr
    } irq_state_e;

    localparam logic [7:0] DefaultMaskAddr = 8'hF0;
    localparam logic [7:0] DefaultStatAddr = 8'hF1;

    function automatic logic addr_in_range(input logic [7:0]  addr,
                                           input logic [7:0]  base,
                                           input int unsigned num);
        int unsigned a;
        int unsigned b;
        a = 32'(addr);
        b = 32'(base);
        return (a >= b) && (a < b + num);
    endfunction

endpackage

// File: rtl/pb_io_hub_if.sv
// pb_io_hub_if: PicoBlaze CPU-side I/O bus.
//   port_id       - port address from the CPU
//   read_strobe   - CPU read strobe
//   write_strobe  - CPU write strobe
//   out_port      - CPU write data
//   in_port       - read data returned to the CPU
//   interrupt     - interrupt request to the CPU
//   interrupt_ack - interrupt acknowledge from the CPU
// Modports: master = CPU side, slave = hub side.
interface pb_io_hub_if #(
    parameter int unsigned DATA_W = 8
);
    logic [7:0]        port_id;
    logic              read_strobe;
    logic              write_strobe;
    logic [DATA_W-1:0] out_port;
    logic [DATA_W-1:0] in_port;
    logic              interrupt;
    logic              interrupt_ack;

    modport master (
        output port_id, read_strobe, write_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, read_strobe, write_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/pb_irq_ctrl.sv
// pb_irq_ctrl: edge-triggered, maskable interrupt controller.
//   clk, reset     - clock, synchronous active-high reset
//   in_event       - level event inputs; rising edges set pending bits
//   mask_we        - load mask from wdata
//   stat_we        - write-1-to-clear pending bits using wdata
//   wdata          - register write data
//   interrupt_ack  - acknowledge from the CPU
//   mask, pending  - register contents for read-back
//   interrupt      - interrupt request to the CPU
module pb_irq_ctrl
    import pb_io_pkg::*;
#(
    parameter int unsigned NUM_IN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] in_event,
    input  logic              mask_we,
    input  logic              stat_we,
    input  logic [NUM_IN-1:0] wdata,
    input  logic              interrupt_ack,
    output logic [NUM_IN-1:0] mask,
    output logic [NUM_IN-1:0] pending,
    output logic              interrupt
);

    logic [NUM_IN-1:0] event_q;
    logic [NUM_IN-1:0] mask_q, mask_d;
    logic [NUM_IN-1:0] pending_q, pending_d;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] clr;
    irq_state_e        state_q, state_d;

    assign rise = in_event & ~event_q;
    assign clr  = stat_we ? wdata : '0;

    always_comb begin
        mask_d    = mask_we ? wdata : mask_q;
        // A new edge outranks a simultaneous clear so no event is lost.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_comb begin
        state_d   = state_q;
        interrupt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|(pending_q & mask_q)) state_d = StAssert;
            end
            StAssert: begin
                interrupt = 1'b1;
                if (interrupt_ack) state_d = StWaitClr;
            end
            StWaitClr: begin
                // Hold off re-assertion until the ISR has cleared its sources.
                if ((pending_q & mask_q) == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_q   <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            state_q   <= StIdle;
        end else begin
            event_q   <= in_event;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    assign mask    = mask_q;
    assign pending = pending_q;

endmodule

// File: rtl/pb_io_hub.sv
// pb_io_hub: PicoBlaze I/O hub with address decode, registered read mux,
// output port latches and an interrupt controller.
//   clk, reset - clock, synchronous active-high reset
//   cpu        - CPU bus (pb_io_hub_if.slave)
//   in_data    - input port data, port i = [i*DATA_W +: DATA_W]
//   in_event   - level status per input port
//   read_ack   - one-cycle pulse per input port read
//   out_data   - latched value per output port
//   out_we     - one-cycle write-enable pulse per output port
module pb_io_hub
    import pb_io_pkg::*;
#(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned NUM_OUT   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter logic [7:0]  IN_BASE   = 8'h00,
    parameter logic [7:0]  OUT_BASE  = 8'h00,
    parameter logic [7:0]  MASK_ADDR = DefaultMaskAddr,
    parameter logic [7:0]  STAT_ADDR = DefaultStatAddr
) (
    input  logic                      clk,
    input  logic                      reset,
    pb_io_hub_if.slave                cpu,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN-1:0]         in_event,
    output logic [NUM_IN-1:0]         read_ack,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_we
);

    if (NUM_IN < 1 || NUM_IN > DATA_W) begin : g_bad_num_in
        $error("pb_io_hub: NUM_IN must be within 1..DATA_W");
    end
    if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num_out
        $error("pb_io_hub: NUM_OUT must be within 1..16");
    end
    if (32'(IN_BASE) + NUM_IN > 256) begin : g_bad_in_range
        $error("pb_io_hub: input range wraps past 8'hFF");
    end
    if (32'(OUT_BASE) + NUM_OUT > 256) begin : g_bad_out_range
        $error("pb_io_hub: output range wraps past 8'hFF");
    end
    if (MASK_ADDR == STAT_ADDR) begin : g_bad_ctrl_addr
        $error("pb_io_hub: MASK_ADDR and STAT_ADDR must differ");
    end

    logic                      hit_mask, hit_stat, hit_in, hit_out;
    logic [7:0]                in_idx, out_idx;
    logic [DATA_W-1:0]         in_port_q, in_port_d;
    logic [NUM_IN-1:0]         read_ack_q, read_ack_d;
    logic [NUM_OUT-1:0]        out_we_q, out_we_d;
    logic [NUM_OUT*DATA_W-1:0] out_data_q;
    logic [NUM_IN-1:0]         irq_mask, irq_pending;
    logic                      irq;

    // Control registers shadow any data port that shares their address.
    always_comb begin
        hit_mask = (cpu.port_id == MASK_ADDR);
        hit_stat = !hit_mask && (cpu.port_id == STAT_ADDR);
        hit_in   = !hit_mask && !hit_stat && addr_in_range(cpu.port_id, IN_BASE, NUM_IN);
        hit_out  = !hit_mask && !hit_stat && addr_in_range(cpu.port_id, OUT_BASE, NUM_OUT);
        in_idx   = cpu.port_id - IN_BASE;
        out_idx  = cpu.port_id - OUT_BASE;
    end

    always_comb begin
        in_port_d  = '0;
        read_ack_d = '0;
        if (hit_mask) begin
            in_port_d[NUM_IN-1:0] = irq_mask;
        end else if (hit_stat) begin
            in_port_d[NUM_IN-1:0] = irq_pending;
        end else if (hit_in) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (in_idx == 8'(i)) begin
                    in_port_d     = in_data[i*DATA_W +: DATA_W];
                    read_ack_d[i] = cpu.read_strobe;
                end
            end
        end
    end

    always_comb begin
        out_we_d = '0;
        if (hit_out) begin
            for (int j = 0; j < int'(NUM_OUT); j++) begin
                if (out_idx == 8'(j)) out_we_d[j] = cpu.write_strobe;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_port_q  <= '0;
            read_ack_q <= '0;
            out_we_q   <= '0;
            out_data_q <= '0;
        end else begin
            in_port_q  <= in_port_d;
            read_ack_q <= read_ack_d;
            out_we_q   <= out_we_d;
            for (int j = 0; j < int'(NUM_OUT); j++) begin
                if (out_we_d[j]) out_data_q[j*DATA_W +: DATA_W] <= cpu.out_port;
            end
        end
    end

    pb_irq_ctrl #(
        .NUM_IN (NUM_IN)
    ) u_irq_ctrl (
        .clk           (clk),
        .reset         (reset),
        .in_event      (in_event),
        .mask_we       (cpu.write_strobe && hit_mask),
        .stat_we       (cpu.write_strobe && hit_stat),
        .wdata         (cpu.out_port[NUM_IN-1:0]),
        .interrupt_ack (cpu.interrupt_ack),
        .mask          (irq_mask),
        .pending       (irq_pending),
        .interrupt     (irq)
    );

    assign cpu.in_port   = in_port_q;
    assign cpu.interrupt = irq;
    assign read_ack      = read_ack_q;
    assign out_we        = out_we_q;
    assign out_data      = out_data_q;

endmodule

// File: tb/tb_pb_io_hub.sv
// tb_pb_io_hub: directed scoreboard bench for pb_io_hub (default parameters).
module tb_pb_io_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_event;
    logic [3:0]  read_ack;
    logic [31:0] out_data;
    logic [3:0]  out_we;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    pb_io_hub_if #(.DATA_W(8)) bus ();

    pb_io_hub dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (bus.slave),
        .in_data  (in_data),
        .in_event (in_event),
        .read_ack (read_ack),
        .out_data (out_data),
        .out_we   (out_we)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        bus.port_id      = addr;
        bus.out_port     = data;
        bus.write_strobe = 1'b1;
        step();
        bus.write_strobe = 1'b0;
    endtask

    task automatic ack_irq();
        bus.interrupt_ack = 1'b1;
        step();
        bus.interrupt_ack = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        in_data           = 32'h44A52211;
        in_event          = 4'h0;
        bus.port_id       = 8'h00;
        bus.read_strobe   = 1'b0;
        bus.write_strobe  = 1'b0;
        bus.out_port      = 8'h00;
        bus.interrupt_ack = 1'b0;
        step();
        step();
        expect_val("rst_in_port", 32'h0);
        expect_val("rst_read_ack", 32'h0);
        expect_val("rst_out_we", 32'h0);
        expect_val("rst_out_data", 32'h0);
        expect_val("rst_interrupt", 32'h0);
        check(32'(bus.in_port));
        check(32'(read_ack));
        check(32'(out_we));
        check(out_data);
        check(32'(bus.interrupt));
        reset = 1'b0;

        // Read input port 2.
        bus.port_id     = 8'h02;
        bus.read_strobe = 1'b1;
        expect_val("rd2_in_port", 32'hA5);
        expect_val("rd2_read_ack", 32'h4);
        step();
        bus.read_strobe = 1'b0;
        check(32'(bus.in_port));
        check(32'(read_ack));
        expect_val("rd2_ack_drop", 32'h0);
        step();
        check(32'(read_ack));

        // Read input port 0 without a strobe: data but no ack.
        bus.port_id = 8'h00;
        expect_val("rd0_in_port", 32'h11);
        expect_val("rd0_no_ack", 32'h0);
        step();
        check(32'(bus.in_port));
        check(32'(read_ack));

        // Write output port 1.
        expect_val("wr1_out_we", 32'h2);
        expect_val("wr1_out_data", 32'h00003C00);
        cpu_write(8'h01, 8'h3C);
        check(32'(out_we));
        check(out_data);
        expect_val("wr1_we_drop", 32'h0);
        expect_val("wr1_data_hold", 32'h00003C00);
        step();
        check(32'(out_we));
        check(out_data);

        // Mask bit 0 and read it back.
        cpu_write(8'hF0, 8'h01);
        step();
        expect_val("mask_readback", 32'h01);
        check(32'(bus.in_port));

        // Rising edge on event 0: pending then interrupt.
        bus.port_id = 8'hF1;
        in_event    = 4'h1;
        step();
        expect_val("ev0_irq_lat1", 32'h0);
        check(32'(bus.interrupt));
        step();
        expect_val("ev0_irq_lat2", 32'h1);
        expect_val("ev0_pending", 32'h01);
        check(32'(bus.interrupt));
        check(32'(bus.in_port));

        // Ack drops interrupt; it stays low until the W1C.
        ack_irq();
        expect_val("ack_irq_low", 32'h0);
        check(32'(bus.interrupt));
        step();
        step();
        expect_val("waitclr_irq_low", 32'h0);
        check(32'(bus.interrupt));
        cpu_write(8'hF1, 8'h01);
        step();
        expect_val("w1c_irq_low", 32'h0);
        expect_val("w1c_pending", 32'h0);
        check(32'(bus.interrupt));
        check(32'(bus.in_port));

        // A fresh rising edge re-asserts.
        in_event = 4'h0;
        step();
        in_event = 4'h1;
        step();
        step();
        expect_val("rearm_irq", 32'h1);
        check(32'(bus.interrupt));
        ack_irq();
        cpu_write(8'hF1, 8'h01);
        step();

        // Event 3 with mask 0: recorded, no interrupt.
        cpu_write(8'hF0, 8'h00);
        in_event    = 4'h9;
        bus.port_id = 8'hF1;
        step();
        step();
        expect_val("ev3_masked_irq", 32'h0);
        expect_val("ev3_pending", 32'h08);
        check(32'(bus.interrupt));
        check(32'(bus.in_port));
        cpu_write(8'hF0, 8'h08);
        step();
        expect_val("ev3_unmask_irq", 32'h1);
        check(32'(bus.interrupt));
        ack_irq();
        cpu_write(8'hF1, 8'h08);
        cpu_write(8'hF0, 8'h01);
        in_event = 4'h0;
        step();
        step();

        // W1C of bit 0 coinciding with a rise on event 0: set wins.
        in_event = 4'h1;
        cpu_write(8'hF1, 8'h01);
        step();
        expect_val("set_beats_clr", 32'h01);
        check(32'(bus.in_port));
        expect_val("pre_reset_irq", 32'h1);
        check(32'(bus.interrupt));

        // Reset while asserting.
        reset    = 1'b1;
        in_event = 4'h0;
        step();
        reset = 1'b0;
        expect_val("rst_mid_irq", 32'h0);
        check(32'(bus.interrupt));
        step();
        expect_val("rst_mid_pending", 32'h0);
        check(32'(bus.in_port));
        bus.port_id = 8'hF0;
        step();
        expect_val("rst_mid_mask", 32'h0);
        check(32'(bus.in_port));
        bus.port_id = 8'h03;
        step();
        expect_val("rd3_in_port", 32'h44);
        check(32'(bus.in_port));
        bus.port_id = 8'h80;
        step();
        expect_val("unmapped_in_port", 32'h0);
        check(32'(bus.in_port));

        if (sb.size() != 0) begin
            n_mis++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
